// File: rtl/cosim_pkg.sv
// ----------------------------------------------------------------------------
// cosim_pkg
//   Shared types and constants for the cosim signature compactors.
//   - compactor_state_e : run-control state of a compactor
//   - MISR_W            : signature width
//   - MISR_POLY         : feedback taps for x^128 + x^7 + x^2 + x + 1
// ----------------------------------------------------------------------------
package cosim_pkg;

   localparam int MISR_W = 128;

   // The x^128 term is implicit: it is the bit shifted out of the MSB.
   localparam logic [MISR_W-1:0] MISR_POLY = 128'h87;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } compactor_state_e;

endpackage : cosim_pkg

// File: rtl/cosim_misr128.sv
// ----------------------------------------------------------------------------
// cosim_misr128
//   Purely combinational next-state function of a 128-bit MISR.
//   Shift left by one, fold the outgoing MSB back through the feedback
//   polynomial, then XOR in the new data vector.
//
// Ports:
//   sig      in  128  current signature
//   data     in  128  vector being folded in
//   sig_next out 128  signature after absorbing data
// ----------------------------------------------------------------------------
module cosim_misr128
   import cosim_pkg::*;
(
   input  logic [MISR_W-1:0] sig,
   input  logic [MISR_W-1:0] data,
   output logic [MISR_W-1:0] sig_next
);

   logic [MISR_W-1:0] feedback;

   assign feedback = sig[MISR_W-1] ? MISR_POLY : '0;
   assign sig_next = {sig[MISR_W-2:0], 1'b0} ^ feedback ^ data;

endmodule : cosim_misr128

// File: rtl/cosim_out_compactor.sv
// ----------------------------------------------------------------------------
// cosim_out_compactor
//   Folds a programmed number of 128-bit result vectors from a cosim spec
//   module into a MISR signature and compares it against a golden value, so
//   a long run reports a single pass/fail.
//
// Parameters:
//   SEED   signature loaded on reset and on every start
//   CNT_W  width of the vector counter and num_vectors
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin a run (honoured in IDLE or DONE only)
//   num_vectors  in   CNT_W  vectors in the run, sampled with start
//   golden       in   128    expected signature, compared while done
//   in_valid     in   1      upstream vector valid
//   in_data      in   128    upstream vector
//   in_ready     out  1      accepting vectors (RUN)
//   busy         out  1      run in progress (RUN)
//   done         out  1      run complete (DONE)
//   pass         out  1      done && signature == golden
//   signature    out  128    current MISR value
//   count        out  CNT_W  vectors accepted in the current run
// ----------------------------------------------------------------------------
module cosim_out_compactor
   import cosim_pkg::*;
#(
   parameter logic [MISR_W-1:0] SEED  = '0,
   parameter int                CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vectors,
   input  logic [MISR_W-1:0] golden,
   input  logic              in_valid,
   input  logic [MISR_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature,
   output logic [CNT_W-1:0]  count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   compactor_state_e  state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  target_q, target_d;
   logic [MISR_W-1:0] sig_q, sig_d;

   logic [MISR_W-1:0] sig_step;
   logic [CNT_W-1:0]  count_inc;
   logic              accept;
   logic              start_ok;

   cosim_misr128 u_misr (
      .sig      (sig_q),
      .data     (in_data),
      .sig_next (sig_step)
   );

   // in_ready is decoded from registered state only, so accept never forms a
   // combinational loop through the upstream handshake.
   assign accept    = in_valid && (state_q == RUN);
   assign start_ok  = start && (state_q != RUN);
   assign count_inc = count_q + CNT_ONE;

   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      sig_d    = sig_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               sig_d    = SEED;
               count_d  = '0;
               target_d = num_vectors;
               state_d  = (num_vectors == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               sig_d   = sig_step;
               count_d = count_inc;
               // Compare the incremented count with the target: target is
               // never zero in RUN, and this avoids computing target-1.
               if (count_inc == target_q) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         target_q <= '0;
         sig_q    <= SEED;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         sig_q    <= sig_d;
      end
   end

   assign in_ready  = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   // golden is live; only the signature side is registered.
   assign pass      = done && (sig_q == golden);
   assign signature = sig_q;
   assign count     = count_q;

endmodule : cosim_out_compactor
